wb_invsqrt_master: RTL and testbench

Wishbone classic-cycle bus master that drives the `fastInvSqrt_top` slave on behalf of on-chip logic (e.g. the madgwick filter datapath). It turns each operand request on a valid/ready port into a single write of the operand, a programmable settle gap, and a single read of the result. It then returns the result, with an error flag, on a valid/ready response port. It is the initiator end of the same 16-bit data / 32-bit address Wishbone link the slave exposes.

---
 rtl/wb_invsqrt_master.sv | 200 ++++++++++++++++++++
 tb/tb_wb_invsqrt_master.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_invsqrt_master.sv
// Wishbone classic-cycle master for the fastInvSqrt slave.
// Each accepted operand becomes one write cycle, an idle settle gap and one read
// cycle; the read data (or a timeout error) is then offered on a valid/ready port.
module wb_invsqrt_master #(
  parameter logic [31:0] OPERAND_ADR = 32'h0000_0000,
  parameter logic [31:0] RESULT_ADR  = 32'h0000_0000,
  parameter int unsigned GAP_CYCLES  = 20,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,

  output logic        busy,

  output logic [31:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  output logic        we_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StGap,
    StRead,
    StResp
  } state_e;

  localparam logic [15:0] GapLoad   = 16'(GAP_CYCLES);
  localparam logic [15:0] ToLimit   = 16'(ACK_TIMEOUT);
  localparam bit          ToEnable  = (ACK_TIMEOUT != 0);
  localparam bit          GapIsZero = (GAP_CYCLES == 0);

  state_e      r_state;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_to_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_busy;
  logic [31:0] r_adr;
  logic [15:0] r_dat;
  logic        r_we;
  logic        r_stb;
  logic        r_cyc;

  logic [15:0] w_to_next;
  logic        w_to_hit;

  // Timeout fires on the edge that would bring the no-ack count up to the limit.
  always_comb begin
    w_to_next = r_to_cnt + 16'd1;
    w_to_hit  = ToEnable && (w_to_next == ToLimit);
  end

  // Transaction sequencer; every bus and response output is a register here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_gap_cnt   <= 16'd0;
      r_to_cnt    <= 16'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_adr       <= 32'd0;
      r_dat       <= 16'd0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_state     <= StWrite;
            r_to_cnt    <= 16'd0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_adr       <= OPERAND_ADR;
            r_dat       <= req_data;
            r_we        <= 1'b1;
            r_stb       <= 1'b1;
            r_cyc       <= 1'b1;
          end
        end

        StWrite: begin
          if (ack_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_to_cnt  <= 16'd0;
            r_gap_cnt <= GapLoad;
            // With no gap the read still starts one cycle later so the write
            // cycle visibly ends with cyc_o low for a cycle.
            r_state   <= GapIsZero ? StRead : StGap;
          end else if (w_to_hit) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_to_cnt <= w_to_next;
          end
        end

        StGap: begin
          if (r_gap_cnt <= 16'd1) begin
            r_state  <= StRead;
            r_to_cnt <= 16'd0;
            r_adr    <= RESULT_ADR;
            r_we     <= 1'b0;
            r_stb    <= 1'b1;
            r_cyc    <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end

        StRead: begin
          if (!r_cyc) begin
            // Entered straight from a write ack: raise the read strobe now.
            r_to_cnt <= 16'd0;
            r_adr    <= RESULT_ADR;
            r_we     <= 1'b0;
            r_stb    <= 1'b1;
            r_cyc    <= 1'b1;
          end else if (ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_data  <= dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else if (w_to_hit) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_to_cnt <= w_to_next;
          end
        end

        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end

        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_we        <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports straight from the state registers.
  always_comb begin
    req_ready = r_req_ready;
    rsp_valid = r_rsp_valid;
    rsp_data  = r_rsp_data;
    rsp_err   = r_rsp_err;
    busy      = r_busy;
    adr_o     = r_adr;
    dat_o     = r_dat;
    we_o      = r_we;
    stb_o     = r_stb;
    cyc_o     = r_cyc;
  end

endmodule

// File: tb/tb_wb_invsqrt_master.sv
// Directed bench for wb_invsqrt_master: one instance with a 20-cycle gap and an
// 8-cycle ack timeout behind a programmable-delay slave, and one zero-gap
// instance with the timeout disabled behind a combinational-ack slave.
module tb_wb_invsqrt_master;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [15:0] a_req_data, a_rsp_data, a_dat_o, a_dat_i;
  logic [31:0] a_adr_o;
  logic        a_we, a_stb, a_cyc, a_ack;

  // Instance Z signals
  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [15:0] z_req_data, z_rsp_data, z_dat_o, z_dat_i;
  logic [31:0] z_adr_o;
  logic        z_we, z_stb, z_cyc, z_ack, z_ack_en;

  wb_invsqrt_master #(
    .OPERAND_ADR(32'h0000_0010), .RESULT_ADR(32'h0000_0014),
    .GAP_CYCLES(20), .ACK_TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_data(a_req_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_err(a_rsp_err), .busy(a_busy),
    .adr_o(a_adr_o), .dat_o(a_dat_o), .dat_i(a_dat_i), .we_o(a_we),
    .stb_o(a_stb), .cyc_o(a_cyc), .ack_i(a_ack)
  );

  wb_invsqrt_master #(
    .OPERAND_ADR(32'h0000_0020), .RESULT_ADR(32'h0000_0024),
    .GAP_CYCLES(0), .ACK_TIMEOUT(0)
  ) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_data(z_req_data),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .rsp_err(z_rsp_err), .busy(z_busy),
    .adr_o(z_adr_o), .dat_o(z_dat_o), .dat_i(z_dat_i), .we_o(z_we),
    .stb_o(z_stb), .cyc_o(z_cyc), .ack_i(z_ack)
  );

  assign z_ack = z_stb & z_ack_en;

  // Slave A: acks on the Nth strobe cycle (0 = never) and logs bus activity.
  int          a_wdelay, a_rdelay, a_stb_cnt;
  int          a_wr_stb, a_rd_stb, a_wr_acks, a_rd_acks;
  int          a_gap_run, a_gap_len;
  bit          a_in_gap;
  logic [15:0] a_last_wdat;
  logic [31:0] a_last_wadr, a_last_radr;

  initial begin
    int dly;
    a_ack = 1'b0; a_stb_cnt = 0; a_in_gap = 1'b0; a_gap_run = 0; a_gap_len = -1;
    forever begin
      @(negedge clk);
      if (a_stb) begin
        if (a_in_gap) begin
          a_gap_len = a_gap_run;
          a_in_gap  = 1'b0;
        end
        a_stb_cnt++;
        if (a_we) a_wr_stb++; else a_rd_stb++;
        dly   = a_we ? a_wdelay : a_rdelay;
        a_ack = (dly != 0) && (a_stb_cnt == dly);
        if (a_ack) begin
          if (a_we) begin
            a_wr_acks++; a_last_wdat = a_dat_o; a_last_wadr = a_adr_o;
            a_in_gap = 1'b1; a_gap_run = 0;
          end else begin
            a_rd_acks++; a_last_radr = a_adr_o;
          end
        end
      end else begin
        a_stb_cnt = 0;
        a_ack     = 1'b0;
        if (a_in_gap) a_gap_run++;
      end
    end
  end

  task automatic clear_log();
    a_wr_stb = 0; a_rd_stb = 0; a_wr_acks = 0; a_rd_acks = 0; a_gap_len = -1;
    a_last_wdat = 16'hxxxx; a_last_wadr = 32'hx; a_last_radr = 32'hx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to A and hold it for the accepting edge.
  task automatic a_request(input logic [15:0] d);
    a_req_data  = d;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
  endtask

  // Wait for A's rsp_valid; n returns the cycles counted since the call.
  task automatic a_wait_rsp(input int budget, output int n);
    n = 0;
    while (!a_rsp_valid && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (!a_rsp_valid) begin
      n_fail++;
      $display("FAIL a_wait_rsp: rsp_valid=%0b after %0d cycles, required 1", a_rsp_valid, n);
    end
  endtask

  task automatic a_handshake();
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    // Values while reset is asserted from time zero
    #1;
    n_checks++;
    if ({a_cyc, a_stb, a_we, a_rsp_valid, a_rsp_err, a_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: cyc,stb,we,vld,err,busy=%b required 000000",
               {a_cyc, a_stb, a_we, a_rsp_valid, a_rsp_err, a_busy});
    end
    n_checks++;
    if ({a_adr_o, a_dat_o, a_rsp_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: adr=%h dat=%h rsp=%h required zeros", a_adr_o, a_dat_o, a_rsp_data);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if (a_req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: a=%b z=%b required 1", a_req_ready, z_req_ready);
    end
    // Start a write that the slave never acks, then reset in the middle of it
    a_wdelay = 0;
    a_request(16'h1234);
    n_checks++;
    if ({a_cyc, a_stb, a_we} !== 3'b111 || a_dat_o !== 16'h1234 || a_adr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL accept_write: cyc,stb,we=%b dat=%h adr=%h required 111 1234 10",
               {a_cyc, a_stb, a_we}, a_dat_o, a_adr_o);
    end
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_cyc, a_stb, a_we, a_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_write: cyc,stb,we,busy=%b required 0000", {a_cyc, a_stb, a_we, a_busy});
    end
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (a_req_ready !== 1'b1 || a_cyc !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b cyc=%b busy=%b required 1 0 0",
               a_req_ready, a_cyc, a_busy);
    end
  endtask

  task automatic test_nominal();
    int n;
    clear_log();
    a_wdelay = 2; a_rdelay = 2; a_dat_i = 16'h5A5A;
    a_request(16'h0008);
    a_wait_rsp(100, n);
    // 2 write cycles + 20 gap cycles + 2 read cycles
    n_checks++;
    if (n !== 24) begin
      n_fail++;
      $display("FAIL nominal_latency: %0d cycles, required 24", n);
    end
    n_checks++;
    if (a_wr_acks !== 1 || a_last_wdat !== 16'h0008 || a_last_wadr !== 32'h10) begin
      n_fail++;
      $display("FAIL nominal_write: acks=%0d dat=%h adr=%h required 1 0008 10",
               a_wr_acks, a_last_wdat, a_last_wadr);
    end
    n_checks++;
    if (a_gap_len !== 20) begin
      n_fail++;
      $display("FAIL nominal_gap: %0d idle cycles, required 20", a_gap_len);
    end
    n_checks++;
    if (a_rd_acks !== 1 || a_last_radr !== 32'h14 || a_rd_stb !== 2) begin
      n_fail++;
      $display("FAIL nominal_read: acks=%0d adr=%h stb=%0d required 1 14 2",
               a_rd_acks, a_last_radr, a_rd_stb);
    end
    n_checks++;
    if (a_rsp_data !== 16'h5A5A || a_rsp_err !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_rsp: data=%h err=%b busy=%b required 5a5a 0 1",
               a_rsp_data, a_rsp_err, a_busy);
    end
    a_handshake();
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_release: vld=%b ready=%b busy=%b required 0 1 0",
               a_rsp_valid, a_req_ready, a_busy);
    end
  endtask

  task automatic test_zero_gap();
    logic [3:0] cyc_hist;
    logic [3:0] we_hist;
    z_ack_en = 1'b1; z_dat_i = 16'hC3C3;
    z_req_data = 16'hBEEF; z_req_valid = 1'b1;
    tick();
    z_req_valid = 1'b0;
    cyc_hist[0] = z_cyc; we_hist[0] = z_we;
    n_checks++;
    if (z_dat_o !== 16'hBEEF || z_adr_o !== 32'h20) begin
      n_fail++;
      $display("FAIL zgap_write: dat=%h adr=%h required beef 20", z_dat_o, z_adr_o);
    end
    tick(); cyc_hist[1] = z_cyc; we_hist[1] = z_we;
    tick(); cyc_hist[2] = z_cyc; we_hist[2] = z_we;
    n_checks++;
    if (z_adr_o !== 32'h24) begin
      n_fail++;
      $display("FAIL zgap_read_adr: adr=%h required 24", z_adr_o);
    end
    tick(); cyc_hist[3] = z_rsp_valid; we_hist[3] = z_we;
    // write, bubble, read, then rsp_valid on the third edge after accept
    n_checks++;
    if (cyc_hist !== 4'b1101 || we_hist !== 4'b0001) begin
      n_fail++;
      $display("FAIL zgap_sequence: cyc/vld=%b we=%b required 1101 0001", cyc_hist, we_hist);
    end
    n_checks++;
    if (z_rsp_data !== 16'hC3C3 || z_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zgap_rsp: data=%h err=%b required c3c3 0", z_rsp_data, z_rsp_err);
    end
    z_rsp_ready = 1'b1; tick(); z_rsp_ready = 1'b0;
  endtask

  task automatic test_timeout_disabled();
    int n;
    z_ack_en = 1'b0; z_dat_i = 16'h0F0F;
    z_req_data = 16'h0001; z_req_valid = 1'b1;
    tick();
    z_req_valid = 1'b0;
    repeat (300) tick();
    n_checks++;
    if (z_cyc !== 1'b1 || z_stb !== 1'b1 || z_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zto_hold: cyc=%b stb=%b vld=%b required 1 1 0", z_cyc, z_stb, z_rsp_valid);
    end
    z_ack_en = 1'b1;
    n = 0;
    while (!z_rsp_valid && n < 20) begin tick(); n++; end
    n_checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_data !== 16'h0F0F || z_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zto_finish: vld=%b data=%h err=%b required 1 0f0f 0",
               z_rsp_valid, z_rsp_data, z_rsp_err);
    end
    z_rsp_ready = 1'b1; tick(); z_rsp_ready = 1'b0;
  endtask

  task automatic test_write_timeout();
    int n;
    clear_log();
    a_wdelay = 0; a_rdelay = 1;
    a_request(16'h1111);
    a_wait_rsp(40, n);
    tick(); tick();
    n_checks++;
    if (a_wr_stb !== 8 || a_rd_stb !== 0) begin
      n_fail++;
      $display("FAIL wto_cycles: write stb=%0d read stb=%0d required 8 0", a_wr_stb, a_rd_stb);
    end
    n_checks++;
    if (a_rsp_err !== 1'b1 || a_rsp_data !== 16'h0000 || a_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL wto_rsp: err=%b data=%h cyc=%b required 1 0000 0", a_rsp_err, a_rsp_data, a_cyc);
    end
    a_handshake();
  endtask

  task automatic test_read_boundary();
    int n;
    // Ack on the 8th read strobe cycle wins over the timeout
    clear_log();
    a_wdelay = 1; a_rdelay = 8; a_dat_i = 16'h7E57;
    a_request(16'h2222);
    a_wait_rsp(60, n);
    n_checks++;
    if (a_rsp_err !== 1'b0 || a_rsp_data !== 16'h7E57 || a_rd_stb !== 8) begin
      n_fail++;
      $display("FAIL rd_boundary: err=%b data=%h stb=%0d required 0 7e57 8",
               a_rsp_err, a_rsp_data, a_rd_stb);
    end
    a_handshake();
    // No read ack at all: error after 8 read strobe cycles
    clear_log();
    a_rdelay = 0;
    a_request(16'h3333);
    a_wait_rsp(60, n);
    n_checks++;
    if (a_rsp_err !== 1'b1 || a_rsp_data !== 16'h0000 || a_rd_stb !== 8 || a_wr_acks !== 1) begin
      n_fail++;
      $display("FAIL rd_timeout: err=%b data=%h stb=%0d wacks=%0d required 1 0000 8 1",
               a_rsp_err, a_rsp_data, a_rd_stb, a_wr_acks);
    end
    a_handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    int bad_data, bad_ready, bad_bus;
    clear_log();
    a_wdelay = 1; a_rdelay = 1; a_dat_i = 16'h1357;
    a_request(16'h0042);
    a_req_data = 16'h0099; a_req_valid = 1'b1;
    a_wait_rsp(60, n);
    a_dat_i = 16'hFFFF;
    n = a_wr_stb + a_rd_stb;
    bad_data = 0; bad_ready = 0; bad_bus = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_rsp_data !== 16'h1357 || a_rsp_valid !== 1'b1) bad_data++;
      if (a_req_ready !== 1'b0) bad_ready++;
      if (a_cyc !== 1'b0 || a_stb !== 1'b0) bad_bus++;
    end
    n_checks++;
    if (bad_data !== 0) begin
      n_fail++;
      $display("FAIL stall_data: %0d unstable cycles, last data=%h required 0 cycles 1357",
               bad_data, a_rsp_data);
    end
    n_checks++;
    if (bad_ready !== 0) begin
      n_fail++;
      $display("FAIL stall_ready: req_ready high in %0d cycles, required 0", bad_ready);
    end
    n_checks++;
    if (bad_bus !== 0 || (a_wr_stb + a_rd_stb) !== n) begin
      n_fail++;
      $display("FAIL stall_bus: %0d active cycles, strobes %0d->%0d required none",
               bad_bus, n, a_wr_stb + a_rd_stb);
    end
    a_handshake();
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: vld=%b ready=%b cyc=%b required 0 1 0",
               a_rsp_valid, a_req_ready, a_cyc);
    end
    tick();
    a_req_valid = 1'b0;
    n_checks++;
    if (a_cyc !== 1'b1 || a_we !== 1'b1 || a_dat_o !== 16'h0099 || a_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: cyc=%b we=%b dat=%h ready=%b required 1 1 0099 0",
               a_cyc, a_we, a_dat_o, a_req_ready);
    end
    a_wait_rsp(60, n);
    n_checks++;
    if (a_rsp_data !== 16'hFFFF || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rsp: data=%h err=%b required ffff 0", a_rsp_data, a_rsp_err);
    end
    a_handshake();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_data = 16'h0; a_rsp_ready = 1'b0; a_dat_i = 16'h0;
    a_wdelay = 1; a_rdelay = 1;
    z_req_valid = 1'b0; z_req_data = 16'h0; z_rsp_ready = 1'b0; z_dat_i = 16'h0;
    z_ack_en = 1'b1;
    clear_log();
    test_reset();
    test_nominal();
    test_zero_gap();
    test_timeout_disabled();
    test_write_timeout();
    test_read_boundary();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
